// File: rtl/controlador_pipeline.sv
// controlador_pipeline: run/step sequencer for the MIPS pipeline.
// Owns the global pipeline enable and the pipeline's active-low soft reset,
// executes debug-unit commands (CLEAR/RUN/STEP/STOP), freezes on halt at
// write-back and counts every enabled cycle.
module controlador_pipeline #(
  parameter int CANT_BITS_STEP     = 16,
  parameter int CANT_BITS_CONTADOR = 32,
  parameter int RESET_CYCLES       = 4
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_cmd_valid,
  input  logic [1:0]                    i_cmd,
  input  logic [CANT_BITS_STEP-1:0]     i_cmd_arg,
  output logic                          o_cmd_ready,
  input  logic                          i_halt_detected,
  output logic                          o_enable_pipeline,
  output logic                          o_pipeline_reset_n,
  output logic                          o_done,
  output logic                          o_halted,
  output logic [CANT_BITS_CONTADOR-1:0] o_cycle_count,
  output logic [2:0]                    o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    HALTED = 3'd3,
    CLEAR  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  // clear-counter only needs to hold RESET_CYCLES-1
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t                    state;
  logic [CANT_BITS_STEP-1:0] remaining;
  logic [CW-1:0]             clr_cnt;
  logic                      cmd_fire;
  logic                      halt_seen;

  // STEP and CLEAR are uninterruptible, so commands are held off there
  assign o_cmd_ready = (state == IDLE) || (state == RUN) || (state == HALTED);
  assign o_halted    = (state == HALTED);
  assign o_state     = state;
  assign cmd_fire    = i_cmd_valid & o_cmd_ready;
  // halt only matters on edges that closed an enabled cycle
  assign halt_seen   = i_halt_detected & o_enable_pipeline;

  // sequencer FSM with all outputs registered
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      state              <= IDLE;
      o_enable_pipeline  <= 1'b0;
      o_pipeline_reset_n <= 1'b1;
      o_done             <= 1'b0;
      o_cycle_count      <= '0;
      remaining          <= '0;
      clr_cnt            <= '0;
    end else begin
      o_done <= 1'b0;
      // the edge that ends a RUN/STEP still closes an enabled cycle
      if (o_enable_pipeline) o_cycle_count <= o_cycle_count + 1'b1;

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (i_cmd)
              CMD_RUN: begin
                state             <= RUN;
                o_enable_pipeline <= 1'b1;
              end
              CMD_STEP: begin
                state             <= STEP;
                remaining         <= (i_cmd_arg == '0) ? CANT_BITS_STEP'(1) : i_cmd_arg;
                o_enable_pipeline <= 1'b1;
              end
              CMD_CLEAR: begin
                state              <= CLEAR;
                o_pipeline_reset_n <= 1'b0;
                o_cycle_count      <= '0;
                o_enable_pipeline  <= 1'b0;
                clr_cnt            <= CW'(RESET_CYCLES - 1);
              end
              default: ; // STOP while idle is a no-op
            endcase
          end
        end

        RUN: begin
          // halt beats a simultaneous STOP
          if (halt_seen) begin
            state             <= HALTED;
            o_enable_pipeline <= 1'b0;
            o_done            <= 1'b1;
          end else if (cmd_fire && i_cmd == CMD_STOP) begin
            state             <= IDLE;
            o_enable_pipeline <= 1'b0;
          end
        end

        STEP: begin
          remaining <= remaining - 1'b1;
          // halt overrides completion on the same edge: one done pulse only
          if (halt_seen) begin
            state             <= HALTED;
            o_enable_pipeline <= 1'b0;
            o_done            <= 1'b1;
          end else if (remaining == CANT_BITS_STEP'(1)) begin
            state             <= IDLE;
            o_enable_pipeline <= 1'b0;
            o_done            <= 1'b1;
          end
        end

        HALTED: begin
          o_enable_pipeline <= 1'b0;
          if (cmd_fire && i_cmd == CMD_CLEAR) begin
            state              <= CLEAR;
            o_pipeline_reset_n <= 1'b0;
            o_cycle_count      <= '0;
            clr_cnt            <= CW'(RESET_CYCLES - 1);
          end
        end

        CLEAR: begin
          o_enable_pipeline <= 1'b0;
          if (clr_cnt == '0) begin
            o_pipeline_reset_n <= 1'b1;
            state              <= IDLE;
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end

        default: begin
          state             <= IDLE;
          o_enable_pipeline <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/controlador_pipeline.md
# controlador_pipeline

Run/step sequencer for the MIPS pipeline. It owns the pipeline's global `i_enable_pipeline` and active-low soft reset. It accepts commands from the debug unit: free-run, step N cycles, stop and clear. It freezes the pipeline when the halt flag reaches the write-back stage, and counts every cycle the pipeline was enabled so the debug unit can report it.

## Interface
- `CANT_BITS_STEP`, 16, width of the step-count argument.
- `CANT_BITS_CONTADOR`, 32, width of the enabled-cycle counter.
- `RESET_CYCLES`, 4, cycles that `o_pipeline_reset_n` is held low on CLEAR (≥1).
- `i_clock`  in  1  single clock; controller logic on posedge (pipeline registers use negedge).
- `i_soft_reset`  in  1  asynchronous, active-high reset of this block.
- `i_cmd_valid`  in  1  command present.
- `i_cmd`  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 STOP.
- `i_cmd_arg`  in  CANT_BITS_STEP  step count for STEP; 0 is treated as 1.
- `o_cmd_ready`  out  1  command accepted on posedge when `i_cmd_valid & o_cmd_ready`.
- `i_halt_detected`  in  1  halt flag from the last pipeline stage (changes on negedge).
- `o_enable_pipeline`  out  1  registered enable fed to every stage.
- `o_pipeline_reset_n`  out  1  registered active-low soft reset for the pipeline.
- `o_done`  out  1  one-cycle pulse: STEP finished or halt reached.
- `o_halted`  out  1  high while in HALTED.
- `o_cycle_count`  out  CANT_BITS_CONTADOR  number of enabled cycles since last CLEAR/reset.
- `o_state`  out  3  IDLE=0, RUN=1, STEP=2, HALTED=3, CLEAR=4.

## Operation
- **Reset values** (async, while `i_soft_reset`=1):
  - state IDLE, `o_enable_pipeline`=0, `o_pipeline_reset_n`=1, `o_done`=0, `o_cycle_count`=0.
  - Internal remaining-steps=0 and clear-counter=0.
  - Combinational outputs follow state: `o_cmd_ready`=1, `o_halted`=0, `o_state`=0.
- **`o_cmd_ready`** is combinational from state:
  - 1 in IDLE, RUN and HALTED.
  - 0 in STEP and CLEAR.
- **IDLE:**
  - RUN → RUN, enable=1.
  - STEP → STEP, remaining=max(arg,1), enable=1.
  - CLEAR → CLEAR.
  - STOP is consumed, no effect.
  - `i_halt_detected` is ignored.
- **RUN:**
  - Halt is sampled each posedge while enable=1. If it is 1 → HALTED, enable=0, `o_done`=1 for one cycle.
  - STOP accepted → IDLE, enable=0.
  - Halt and STOP on the same edge: halt wins (HALTED, done pulse).
  - RUN/STEP/CLEAR in RUN are consumed and ignored.
- **STEP:**
  - Each posedge with enable=1 decrements remaining.
  - When remaining==1 at the edge → IDLE, enable=0, `o_done`=1.
  - Halt on an edge → HALTED, enable=0, `o_done`=1. This overrides step completion on the same edge; only one done pulse is produced.
- **HALTED:**
  - enable=0.
  - Only CLEAR has effect (→ CLEAR); RUN/STEP/STOP are consumed and ignored.
- **CLEAR:**
  - Entry edge: `o_pipeline_reset_n`=0, `o_cycle_count`=0, enable=0, clear-counter=RESET_CYCLES-1.
  - The counter decrements each posedge.
  - On the edge where it is 0: `o_pipeline_reset_n`=1 → IDLE.
- **Cycle counter:**
  - Increments on each posedge where `o_enable_pipeline` was 1 before the edge, including the final edge of RUN/STEP.
  - Wraps modulo 2^CANT_BITS_CONTADOR.
  - Cleared only by reset or CLEAR entry.
- **Reset mid-operation:** async return to reset values. Any step in progress is dropped, and `o_pipeline_reset_n` is released immediately.

## Timing
- Command accepted at posedge k → `o_enable_pipeline`=1 from k (registered). The pipeline sees the first enabled negedge at k+½.
- STEP N: enable high for exactly N posedge-to-posedge cycles (N negedges). Done pulse coincides with enable falling. Counter increases by N.
- Halt raised at negedge → sampled next posedge → enable low from that posedge. No further enabled negedge occurs after the halt was seen.
- CLEAR: reset low for exactly RESET_CYCLES cycles. IDLE and `o_cmd_ready`=1 on the following cycle.
- Latency of every transition: 1 posedge; no combinational path from inputs to registered outputs.

## Test plan
- Reset then STEP arg=3 → enable high 3 cycles, `o_done` pulse on the 3rd edge, count=3, state IDLE, ready=1.
- STEP arg=0 → behaves as 1: enable high 1 cycle, done pulse, count=1.
- RUN, then raise `i_halt_detected` after 10 enabled cycles → HALTED, enable=0, done pulse, count=10. A subsequent RUN is ignored; CLEAR gives reset_n low 4 cycles, count=0, IDLE.
- RUN with STOP and halt asserted on the same edge → HALTED, not IDLE; single done pulse.
- STEP arg=5 with a new command valid during the step → ready=0, command not consumed until IDLE. After done, the held STEP is accepted.
- Assert `i_soft_reset` mid-CLEAR and mid-STEP → immediately enable=0, reset_n=1, count=0, state IDLE; preload count near 2^32-1 via long RUN (reduced width sim: CANT_BITS_CONTADOR=4) → wraps 15→0.
